// File: rtl/spi_frame_engine.sv
// spi_frame_engine: bit-level mode-3 SPI master for the ADXL345 path.
// Takes one command word per start/done handshake and runs one framed,
// MSB-first transfer. SPI_CLK is the phase-shifted spi_clk_out, gated
// open only while bits are being shifted. The gate register updates on
// spi_clk rising edges, at a point where spi_clk_out is still high, so
// opening or closing the gate never produces a runt pulse.
module spi_frame_engine #(
   parameter int TX_WIDTH = 16,
   parameter int RX_WIDTH = 8,
   parameter int CS_SETUP = 1,
   parameter int CS_HOLD  = 1,
   parameter int CS_IDLE  = 2
) (
   input  logic                spi_clk,
   input  logic                reset_n,
   input  logic                spi_clk_out,
   input  logic [TX_WIDTH-1:0] data_tx,
   input  logic                start,
   output logic                done,
   output logic [RX_WIDTH-1:0] data_rx,
   output logic                busy,
   output logic                SPI_SDI,
   input  logic                SPI_SDO,
   output logic                SPI_CSN,
   output logic                SPI_CLK
);

   localparam int BIT_W   = (TX_WIDTH > 1) ? $clog2(TX_WIDTH) : 1;
   localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int CNT_MAX = (MAX_SH > CS_IDLE) ? MAX_SH : CS_IDLE;
   localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(TX_WIDTH - 1);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(CS_SETUP);
   localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(CS_HOLD);
   localparam logic [CNT_W-1:0] CNT_IDLE  = CNT_W'(CS_IDLE);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      DONE,
      GAP
   } state_t;

   state_t              state;
   logic [TX_WIDTH-1:0] tx_shift;
   logic [RX_WIDTH-1:0] rx_shift;
   logic [RX_WIDTH-1:0] rx_next;
   logic [BIT_W-1:0]    bit_cnt;
   logic [CNT_W-1:0]    cnt;
   logic                gate_en;

   // Next content of the receive shifter with the current SDO bit appended
   generate
      if (RX_WIDTH == 1) begin : g_rx_single
         assign rx_next = SPI_SDO;
      end else begin : g_rx_multi
         assign rx_next = {rx_shift[RX_WIDTH-2:0], SPI_SDO};
      end
   endgenerate

   // Serial clock: forced high whenever the gate is closed
   assign SPI_CLK = spi_clk_out | ~gate_en;

   // Frame sequencer: chip select framing, bit shifting and handshake
   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         tx_shift <= '0;
         rx_shift <= '0;
         data_rx  <= '0;
         bit_cnt  <= '0;
         cnt      <= '0;
         gate_en  <= 1'b0;
         SPI_CSN  <= 1'b1;
         SPI_SDI  <= 1'b1;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  SPI_CSN <= 1'b0;
                  if (CS_SETUP == 0) begin
                     SPI_SDI  <= data_tx[TX_WIDTH-1];
                     tx_shift <= data_tx << 1;
                     gate_en  <= 1'b1;
                     bit_cnt  <= '0;
                     state    <= SHIFT;
                  end else begin
                     tx_shift <= data_tx;
                     cnt      <= CNT_SETUP;
                     state    <= SETUP;
                  end
               end
            end
            SETUP: begin
               if (cnt == CNT_ONE) begin
                  SPI_SDI  <= tx_shift[TX_WIDTH-1];
                  tx_shift <= tx_shift << 1;
                  gate_en  <= 1'b1;
                  bit_cnt  <= '0;
                  state    <= SHIFT;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            SHIFT: begin
               rx_shift <= rx_next;
               if (bit_cnt == LAST_BIT) begin
                  data_rx <= rx_next;
                  gate_en <= 1'b0;
                  SPI_SDI <= 1'b1;
                  if (CS_HOLD == 0) begin
                     SPI_CSN <= 1'b1;
                     done    <= 1'b1;
                     state   <= DONE;
                  end else begin
                     cnt   <= CNT_HOLD;
                     state <= HOLD;
                  end
               end else begin
                  SPI_SDI  <= tx_shift[TX_WIDTH-1];
                  tx_shift <= tx_shift << 1;
                  bit_cnt  <= bit_cnt + BIT_ONE;
               end
            end
            HOLD: begin
               if (cnt == CNT_ONE) begin
                  SPI_CSN <= 1'b1;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            DONE: begin
               if (!start) begin
                  done <= 1'b0;
                  if (CS_IDLE == 0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     cnt   <= CNT_IDLE;
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (cnt == CNT_ONE) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_engine.sv
// tb_spi_frame_engine: directed bench for spi_frame_engine with a small
// behavioural ADXL345-style slave that captures SDI on SPI_CLK rising
// edges and drives SDO on falling edges during the trailing byte.
module tb_spi_frame_engine;

   logic        spi_clk;
   logic        spi_clk_out;
   logic        reset_n;
   logic [15:0] data_tx;
   logic        start;
   logic        done;
   logic [7:0]  data_rx;
   logic        busy;
   logic        SPI_SDI;
   logic        SPI_SDO;
   logic        SPI_CSN;
   logic        SPI_CLK;

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  sdo_byte = 8'h00;
   logic [15:0] mosi_word = 16'h0000;
   int          rise_cnt = 0;
   int          fall_cnt = 0;

   spi_frame_engine dut (
      .spi_clk     (spi_clk),
      .reset_n     (reset_n),
      .spi_clk_out (spi_clk_out),
      .data_tx     (data_tx),
      .start       (start),
      .done        (done),
      .data_rx     (data_rx),
      .busy        (busy),
      .SPI_SDI     (SPI_SDI),
      .SPI_SDO     (SPI_SDO),
      .SPI_CSN     (SPI_CSN),
      .SPI_CLK     (SPI_CLK)
   );

   // spi_clk period 20; spi_clk_out leads it by a quarter period
   initial begin
      spi_clk     = 1'b0;
      spi_clk_out = 1'b0;
      #5;
      forever begin
         spi_clk_out = 1'b1;
         #5 spi_clk = 1'b1;
         #5 spi_clk_out = 1'b0;
         #5 spi_clk = 1'b0;
         #5;
      end
   end

   // Slave model: new frame on chip-select fall
   always @(negedge SPI_CSN) begin
      rise_cnt  = 0;
      fall_cnt  = 0;
      mosi_word = 16'h0000;
   end

   // Slave model: capture MOSI on rising SPI_CLK
   always @(posedge SPI_CLK) begin
      rise_cnt++;
      mosi_word = {mosi_word[14:0], SPI_SDI};
   end

   // Slave model: drive MISO on falling SPI_CLK, data only in bits 8..15
   always @(negedge SPI_CLK) begin
      if (fall_cnt >= 8 && fall_cnt <= 15)
         SPI_SDO = sdo_byte[15 - fall_cnt];
      else
         SPI_SDO = 1'b0;
      fall_cnt++;
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge spi_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Raise start with a command, wait for acceptance then done.
   // Reports ticks to accept, ticks from accept to done, and the tick
   // (counted from the call) at which data_rx first left prev_rx.
   task automatic applyStimulus(input logic [15:0] cmd, input logic [7:0] sdo,
                                input logic [7:0] prev_rx,
                                output int accept_wait, output int latency,
                                output int change_at);
      int t;
      t         = 0;
      change_at = -1;
      data_tx   = cmd;
      sdo_byte  = sdo;
      start     = 1'b1;
      accept_wait = 0;
      while (SPI_CSN !== 1'b0 && accept_wait < 20) begin
         tick();
         accept_wait++;
         t++;
         if (change_at < 0 && data_rx !== prev_rx) change_at = t;
      end
      latency = 0;
      while (done !== 1'b1 && latency < 40) begin
         tick();
         latency++;
         t++;
         if (change_at < 0 && data_rx !== prev_rx) change_at = t;
      end
   endtask

   logic [15:0] seq_cmd [7] = '{16'h8000, 16'hB200, 16'hB300, 16'hB400,
                                16'hB500, 16'hB600, 16'hB700};

   initial begin
      int aw, lat, chg, bad;
      int clk_bad, csn_bad, sdi_bad, busy_bad;
      logic [7:0] prev, exp_rx;

      reset_n = 1'b0;
      start   = 1'b0;
      data_tx = 16'h0000;
      SPI_SDO = 1'b0;

      // Reset state, sampled while spi_clk_out is low
      #17;
      checkOutput("reset_csn", SPI_CSN, 1);
      checkOutput("reset_clk", SPI_CLK, 1);
      checkOutput("reset_sdi", SPI_SDI, 1);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_rx", data_rx, 0);
      @(negedge spi_clk);
      reset_n = 1'b1;
      tick();
      tick();

      // Write frame
      applyStimulus(16'h2C09, 8'h3C, 8'h00, aw, lat, chg);
      checkOutput("write_accept", aw, 1);
      checkOutput("write_latency", lat, 18);
      checkOutput("write_csn_at_done", SPI_CSN, 1);
      checkOutput("write_busy_at_done", busy, 1);
      checkOutput("write_mosi", mosi_word, 16'h2C09);
      checkOutput("write_rises", rise_cnt, 16);
      checkOutput("write_falls", fall_cnt, 16);
      checkOutput("write_rx", data_rx, 8'h3C);
      checkOutput("write_rx_change", chg, aw + 17);

      // Handshake hold: done and CSN stay high, no clock activity
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done !== 1'b1 || SPI_CSN !== 1'b1) bad++;
      end
      checkOutput("hold_done_csn", bad, 0);
      checkOutput("hold_rises", rise_cnt, 16);
      start = 1'b0;
      tick();
      checkOutput("hold_done_clear", done, 0);
      checkOutput("hold_gap_busy", busy, 1);

      // Read capture, started right after done cleared
      applyStimulus(16'hB200, 8'hA5, 8'h3C, aw, lat, chg);
      checkOutput("read_accept_gap", aw, 3);
      checkOutput("read_latency", lat, 18);
      checkOutput("read_mosi", mosi_word, 16'hB200);
      checkOutput("read_rx", data_rx, 8'hA5);
      checkOutput("read_rx_change", chg, aw + 17);
      start = 1'b0;
      tick();
      checkOutput("read_done_clear", done, 0);

      // Back-to-back sequencer-style reads
      prev = 8'hA5;
      for (int i = 0; i < 7; i++) begin
         exp_rx = 8'(8'h11 * (i + 1));
         applyStimulus(seq_cmd[i], exp_rx, prev, aw, lat, chg);
         checkOutput($sformatf("seq%0d_accept", i), aw, 3);
         checkOutput($sformatf("seq%0d_latency", i), lat, 18);
         checkOutput($sformatf("seq%0d_mosi", i), mosi_word, seq_cmd[i]);
         checkOutput($sformatf("seq%0d_rx", i), data_rx, exp_rx);
         checkOutput($sformatf("seq%0d_rx_change", i), chg, aw + 17);
         prev  = exp_rx;
         start = 1'b0;
         tick();
         checkOutput($sformatf("seq%0d_done_clear", i), done, 0);
      end

      // Reset in the middle of bit 7
      data_tx  = 16'h2C09;
      sdo_byte = 8'h00;
      start    = 1'b1;
      aw = 0;
      while (SPI_CSN !== 1'b0 && aw < 20) begin
         tick();
         aw++;
      end
      checkOutput("abort_accept", aw, 3);
      for (int i = 0; i < 8; i++) tick();
      #5;
      checkOutput("abort_clk_low_before", SPI_CLK, 0);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_csn", SPI_CSN, 1);
      checkOutput("abort_clk", SPI_CLK, 1);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_rx", data_rx, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_sdi", SPI_SDI, 1);
      start = 1'b0;
      @(negedge spi_clk);
      reset_n = 1'b1;
      tick();

      // Fresh frame after the abort
      applyStimulus(16'h2D08, 8'h5A, 8'h00, aw, lat, chg);
      checkOutput("post_accept", aw, 1);
      checkOutput("post_latency", lat, 18);
      checkOutput("post_mosi", mosi_word, 16'h2D08);
      checkOutput("post_rises", rise_cnt, 16);
      checkOutput("post_rx", data_rx, 8'h5A);
      checkOutput("post_rx_change", chg, aw + 17);
      start = 1'b0;
      tick();

      // Idle line, sampled while spi_clk_out is low
      for (int i = 0; i < 4; i++) tick();
      clk_bad = 0;
      csn_bad = 0;
      sdi_bad = 0;
      busy_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         #5;
         if (SPI_CLK !== 1'b1) clk_bad++;
         if (SPI_CSN !== 1'b1) csn_bad++;
         if (SPI_SDI !== 1'b1) sdi_bad++;
         if (busy !== 1'b0) busy_bad++;
      end
      checkOutput("idle_clk", clk_bad, 0);
      checkOutput("idle_csn", csn_bad, 0);
      checkOutput("idle_sdi", sdi_bad, 0);
      checkOutput("idle_busy", busy_bad, 0);
      checkOutput("idle_rises", rise_cnt, 16);
      checkOutput("idle_rx_held", data_rx, 8'h5A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
